// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter.
// State encoding, counter width and default bus timeout.
package mem_arb_pkg;

  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  // Data wins a tie unless data held the port last time.
  function automatic logic pick_data(
    input logic want_if,
    input logic want_dm,
    input logic last_dm
  );
    return want_dm & (~want_if | ~last_dm);
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Busy-cycle counter for the memory port arbiter.
// Raises expire on the last allowed cycle without an ack.
module arb_timeout_counter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = en & (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data stages,
// one transaction at a time, with flush drop and bus timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  arb_state_t state;
  logic       last_dm;
  logic       drop;
  logic       idle;
  logic       want_if;
  logic       want_dm;
  logic       grant_dm;
  logic       grant_if;
  logic       done;
  logic       expire;

  // A requester whose pulse is on the bus this cycle is not re-granted.
  assign idle     = (state == IDLE);
  assign want_if  = if_req & ~if_valid & ~flush;
  assign want_dm  = dm_req & ~dm_valid;
  assign grant_dm = idle & pick_data(want_if, want_dm, last_dm);
  assign grant_if = idle & want_if & ~grant_dm;
  assign done     = mem_ack | expire;

  assign stall_if  = reset_n & if_req & ~if_valid & ~flush;
  assign stall_mem = reset_n & dm_req & ~dm_valid;

  arb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (grant_dm | grant_if),
    .en     (~idle & ~mem_ack),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_dm   <= 1'b0;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_dm) begin
            state     <= BUSY_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= dm_be;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            last_dm   <= 1'b1;
          end else if (grant_if) begin
            state     <= BUSY_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'hF;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            last_dm   <= 1'b0;
            drop      <= 1'b0;
          end
        end
        BUSY_IF: begin
          if (done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            drop    <= 1'b0;
            if (!(drop || flush)) begin
              if_valid <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end
            if (!mem_ack) begin
              bus_err <= 1'b1;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (done) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            dm_valid <= 1'b1;
            if (!mem_ack) begin
              bus_err  <= 1'b1;
              dm_rdata <= '0;
            end else if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural
// sparse memory, randomized fetch/data traffic and directed cases.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic        flush = 1'b0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        if_valid, dm_valid, stall_if, stall_mem;
  logic        mem_req, mem_we, mem_ack, bus_err;
  logic [3:0]  mem_be;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .flush    (flush),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_be    (dm_be),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          req_cycles = 0;
  int          valid_seen = 0;
  int          resp_mode = 0;
  bit          force_en = 1'b0;
  bit          late_ack = 1'b0;
  logic [31:0] force_data = '0;
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] ram[logic [31:0]];
  logic [31:0] refm[logic [31:0]];
  logic [31:0] ref_dm_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_word(a);
  endfunction

  // Memory side: random/fixed/no latency, checks field stability.
  initial begin : responder
    int          wait_left;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    wait_left = -1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        wait_left = -1;
      end else if (late_ack) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        late_ack = 1'b0;
      end else if (mem_req) begin
        if (wait_left < 0) begin
          cap_addr = mem_addr;
          cap_wdata = mem_wdata;
          cap_be = mem_be;
          cap_we = mem_we;
          wait_left = (resp_mode == 1) ? 2 : int'($urandom_range(0, 2));
        end else begin
          chk("mem_addr_stable", mem_addr, cap_addr);
          chk("mem_wdata_stable", mem_wdata, cap_wdata);
          chk("mem_be_stable", {28'h0, mem_be}, {28'h0, cap_be});
          chk("mem_we_stable", {31'h0, mem_we}, {31'h0, cap_we});
        end
        if (resp_mode != 2 && wait_left == 0) begin
          if (mem_we) begin
            ram[mem_addr] = merge(ram_rd(mem_addr), mem_wdata, mem_be);
            mem_rdata = $urandom;
          end else begin
            mem_rdata = ram_rd(mem_addr);
          end
          if (force_en) begin
            mem_rdata = force_data;
            force_en = 1'b0;
          end
          mem_ack = 1'b1;
        end else if (wait_left > 0) begin
          wait_left--;
        end
      end else begin
        wait_left = -1;
      end
    end
  end

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (if_valid) begin
        valid_seen++;
        if (if_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL if_unexpected: got pulse rdata=%h required none",
                   if_rdata);
        end else begin
          e = if_q.pop_front();
          chk("if_rdata", if_rdata, e);
        end
      end
      if (dm_valid) begin
        valid_seen++;
        if (dm_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dm_unexpected: got pulse rdata=%h required none",
                   dm_rdata);
        end else begin
          e = dm_q.pop_front();
          chk("dm_rdata", dm_rdata, e);
        end
      end
    end
  end

  initial begin : stall_mon
    forever begin
      @(posedge clk);
      #2;
      chk("stall_if", {31'h0, stall_if},
          {31'h0, reset_n & if_req & ~if_valid & ~flush});
      chk("stall_mem", {31'h0, stall_mem},
          {31'h0, reset_n & dm_req & ~dm_valid});
      if (mem_req) req_cycles++;
    end
  end

  task automatic do_fetch(input logic [31:0] a, output time t);
    int n;
    if_q.push_back(ref_rd(a));
    if_addr = a;
    if_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_valid && n < 60);
    if (!if_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL fetch_wait: got no if_valid for %h required one", a);
      void'(if_q.pop_back());
    end
    t = $time;
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit tmo, output time t);
    int n;
    if (tmo) begin
      ref_dm_rdata = '0;
    end else if (we) begin
      refm[a] = merge(ref_rd(a), wd, be);
    end else begin
      ref_dm_rdata = ref_rd(a);
    end
    dm_q.push_back(ref_dm_rdata);
    dm_we = we;
    dm_be = be;
    dm_addr = a;
    dm_wdata = wd;
    dm_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dm_valid && n < 60);
    if (!dm_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL data_wait: got no dm_valid for %h required one", a);
      void'(dm_q.pop_back());
    end
    t = $time;
    dm_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    time tf, td;
    int  n, v0;
    ram[32'h100] = 32'h20010005;
    refm[32'h100] = 32'h20010005;
    #12;
    chk("rst_mem_req", {31'h0, mem_req}, 0);
    chk("rst_if_valid", {31'h0, if_valid}, 0);
    chk("rst_dm_valid", {31'h0, dm_valid}, 0);
    chk("rst_bus_err", {31'h0, bus_err}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // fetch only, ack two cycles after mem_req
    resp_mode = 1;
    do_fetch(32'h100, tf);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_if_rdata", if_rdata, 32'h20010005);

    // simultaneous: data first after reset, then fetch
    @(negedge clk);
    fork
      do_fetch(32'h104, tf);
      do_data(1'b0, 4'hF, 32'h2000, 32'h0, 1'b0, td);
    join
    chk("t2_data_first", {31'h0, td < tf}, 1);
    @(negedge clk);
    do_data(1'b0, 4'hF, 32'h2004, 32'h0, 1'b0, td);
    @(negedge clk);
    fork
      do_fetch(32'h108, tf);
      do_data(1'b0, 4'hF, 32'h2008, 32'h0, 1'b0, td);
    join
    chk("t2_fetch_first", {31'h0, tf < td}, 1);

    // partial store, then read back the merged word
    @(negedge clk);
    do_data(1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF, 1'b0, td);
    chk("t3_mem_we", {31'h0, mem_we}, 1);
    chk("t3_mem_be", {28'h0, mem_be}, 32'h3);
    chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t3_dm_rdata_kept", dm_rdata, ref_dm_rdata);
    @(negedge clk);
    do_data(1'b0, 4'hF, 32'h2000, 32'h0, 1'b0, td);

    // flush one cycle after grant drops the response
    @(negedge clk);
    force_data = 32'hFFFFFFFF;
    force_en = 1'b1;
    if_addr = 32'h1C0;
    if_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mem_req && n < 20);
    chk("t4_grant", {31'h0, mem_req}, 1);
    chk("t4_addr", mem_addr, 32'h1C0);
    flush = 1'b1;
    if_req = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    do_fetch(32'h1C4, tf);

    // randomized concurrent traffic
    resp_mode = 0;
    fork
      begin
        time t;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_fetch(32'h100 + 4 * $urandom_range(0, 63), t);
        end
      end
      begin
        time t;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_data(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                  32'h2000 + 4 * $urandom_range(0, 15), $urandom,
                  1'b0, t);
        end
      end
    join

    // timeout with TIMEOUT=4
    @(negedge clk);
    resp_mode = 2;
    req_cycles = 0;
    do_data(1'b0, 4'hF, 32'h2040, 32'h0, 1'b1, td);
    chk("t5_req_cycles", req_cycles, 4);
    chk("t5_bus_err", {31'h0, bus_err}, 1);
    chk("t5_mem_req", {31'h0, mem_req}, 0);
    chk("t5_dm_rdata", dm_rdata, 0);
    resp_mode = 0;
    @(negedge clk);
    do_fetch(32'h10C, tf);
    chk("t5_bus_err_sticky", {31'h0, bus_err}, 1);

    // reset in the middle of a data access
    @(negedge clk);
    resp_mode = 2;
    dm_we = 1'b0;
    dm_be = 4'hF;
    dm_addr = 32'h2080;
    dm_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mem_req && n < 20);
    chk("t6_busy", {31'h0, mem_req}, 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_mem_req", {31'h0, mem_req}, 0);
    chk("t6_dm_valid", {31'h0, dm_valid}, 0);
    chk("t6_if_valid", {31'h0, if_valid}, 0);
    chk("t6_stall_if", {31'h0, stall_if}, 0);
    chk("t6_stall_mem", {31'h0, stall_mem}, 0);
    chk("t6_bus_err", {31'h0, bus_err}, 0);
    chk("t6_dm_rdata", dm_rdata, 0);
    dm_req = 1'b0;
    ref_dm_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    v0 = valid_seen;
    @(negedge clk);
    late_ack = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_late_ack_ignored", valid_seen - v0, 0);
    resp_mode = 0;
    do_data(1'b0, 4'hF, 32'h2004, 32'h0, 1'b0, td);

    repeat (3) @(negedge clk);
    chk("if_q_empty", if_q.size(), 0);
    chk("dm_q_empty", dm_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the DLX fetch stage (instruction reads) and the memory stage (lw/lh/lb/sw/sh/sb). It sequences one outstanding memory transaction at a time and drives stall_if and stall_mem back to the pipeline. It drops fetch responses killed by a taken branch or jump, and flags a bus error if memory never acknowledges. It sits between the pipeline stages and the memory model/SRAM wrapper.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, maximum cycles to wait for mem_ack before a bus error (1..255, 8-bit counter)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_valid or flush
if_addr  in  ADDR_W  fetch address, word aligned
flush  in  1  branch/jump redirect; kills any in-flight fetch response
dm_req  in  1  data request; held until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_be  in  4  byte enables
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
if_rdata  out  DATA_W  fetched instruction, valid with if_valid
if_valid  out  1  one-cycle fetch completion pulse
dm_rdata  out  DATA_W  load data, valid with dm_valid
dm_valid  out  1  one-cycle data completion pulse (loads and stores)
stall_if  out  1  if_req & ~if_valid
stall_mem  out  1  dm_req & ~dm_valid
mem_req  out  1  memory request, held high until mem_ack
mem_we, mem_be, mem_addr, mem_wdata  out  1/4/ADDR_W/DATA_W  registered transaction fields
mem_ack  in  1  one-cycle completion pulse from memory
mem_rdata  in  DATA_W  read data, valid with mem_ack
bus_err  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset: state IDLE; all outputs 0; last_dm=0; drop=0; counter=0. Asserting reset mid-transaction aborts it immediately, with no valid pulse.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE grant rules:
  - Only dm_req -> BUSY_DM.
  - Only if_req & ~flush -> BUSY_IF.
  - Both pending: fetch wins if last_dm=1, else data wins.
  - On grant: latch the mem_* fields, assert mem_req the next cycle, and set last_dm = (grant is data).
- BUSY_*: mem_req=1 and fields held stable. On mem_ack:
  - Latch mem_rdata into if_rdata or dm_rdata.
  - Pulse if_valid or dm_valid on the following cycle.
  - Return to IDLE.
- Latency: request at cycle N, mem_req at N+1, ack at earliest N+1, valid at N+2. A new grant can occur in the IDLE cycle after ack, so peak throughput is one access per (memory latency + 1) cycles.
- rdata outputs hold their last value between pulses. Stores pulse dm_valid; dm_rdata is unchanged for stores.
- flush:
  - In BUSY_IF (including the same cycle as mem_ack) it sets drop; the ack then returns to IDLE with no if_valid.
  - If flush arrives in the cycle the if_valid pulse is being presented, the pulse still occurs; the pipeline ignores it.
  - In IDLE it blocks a fetch grant that cycle only.
  - It has no effect on BUSY_DM.
- stall outputs are combinational from the requests and valids. stall_if is 0 while flush=1.
- Timeout:
  - The counter clears on grant and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT: set bus_err, drop mem_req, return to IDLE, and pulse the pending requester's valid with rdata=0 so the pipeline is not deadlocked.
- A late mem_ack in IDLE is ignored.
- The controller never issues a new mem_req while one is outstanding.

Decomposition:
- Shared package mem_arb_pkg: state encoding (IDLE=2'd0, BUSY_IF=2'd1, BUSY_DM=2'd2) and the default TIMEOUT constant.
- One natural sub-module, arb_timeout_counter: 8-bit counter with clear, enable and expire output.
- Everything else is a single always block plus registered outputs.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x100, mem_ack 2 cycles after mem_req with rdata=0x20010005 -> mem_addr=0x100; if_valid one cycle later with if_rdata=0x20010005; stall_if=1 until then.
2. Simultaneous requests after reset: if_req and dm_req with a load to 0x2000, both held -> data granted first (dm_valid first), then fetch; repeat dm_req right after -> fetch wins next (alternation, no starvation).
3. Store: dm_we=1, dm_be=4'b0011, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_be=0011 held until ack; dm_valid pulses; dm_rdata unchanged.
4. Flush mid-fetch: flush=1 one cycle after the fetch grant, ack with 0xFFFFFFFF -> no if_valid; a new fetch is granted afterwards and its data returned normally.
5. Timeout: TIMEOUT=4, mem_ack never asserted -> after 4 busy cycles bus_err=1 (sticky), mem_req=0, valid pulse with rdata=0; the next request is served normally.
6. Reset mid-BUSY_DM: reset_n low -> mem_req, valids, stalls and bus_err all 0 immediately; after release a late ack produces no valid.
